// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output serializer.
//   FFT_DATA_W / FFT_IDX_W : default sample width and column-index width
//   LANES                  : lanes per column in one beat
//   BEAT_SAMPLES           : samples emitted per beat (two columns of LANES)
//   beat_t                 : one buffered beat at the default widths
package fft_pkg;

    localparam int FFT_DATA_W   = 32;
    localparam int FFT_IDX_W    = 11;
    localparam int LANES        = 4;
    localparam int BEAT_SAMPLES = 2 * LANES;

    // One complete input beat: 16 data words (4 lanes x re/im x 2 columns)
    // plus the two column indices. Lane k of a column sits at
    // [k*DATA_W +: DATA_W] of the corresponding field.
    typedef struct packed {
        logic [FFT_IDX_W-1:0]          idx_col2;
        logic [FFT_IDX_W-1:0]          idx_col1;
        logic [LANES*FFT_DATA_W-1:0]   col2_i;
        logic [LANES*FFT_DATA_W-1:0]   col2_r;
        logic [LANES*FFT_DATA_W-1:0]   col1_i;
        logic [LANES*FFT_DATA_W-1:0]   col1_r;
    } beat_t;

endpackage

// File: rtl/beat_fifo.sv
// Synchronous FIFO of whole beats.
//   clk, rst   : clock and asynchronous active-high reset (clears storage too)
//   push       : write push_data (ignored when full unless a pop happens too)
//   push_data  : beat to store
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, read straight from the storage registers
//   level      : number of entries held, 0..DEPTH
//   full/empty : level == DEPTH / level == 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module beat_fifo #(
    parameter type T     = fft_pkg::beat_t,
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    T                   mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     level_reg;
    logic               do_push;
    logic               do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a beat when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign level = level_reg;

endmodule

// File: rtl/fft_out_serializer.sv
// Buffers 8-sample FFT output beats and serializes them one sample per
// transfer with a valid/ready handshake on the output side.
//   clk, rst                : clock, asynchronous active-high reset
//   in_valid                : beat present (never back-pressured)
//   in_col{1,2}_{r,i}       : lanes 0..3 of column 1 / column 2, lane k at [k*DATA_W +: DATA_W]
//   in_idx_col1/in_idx_col2 : column indices of the beat
//   out_valid/out_ready     : output handshake
//   out_r/out_i             : serialized sample
//   out_addr                : {column index, lane}
//   out_last                : 8th sample of a beat
//   level                   : beats currently stored
//   overflow                : sticky, a beat arrived with no room and was dropped
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int IDX_W  = FFT_IDX_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [4*DATA_W-1:0]      in_col1_r,
    input  logic [4*DATA_W-1:0]      in_col1_i,
    input  logic [4*DATA_W-1:0]      in_col2_r,
    input  logic [4*DATA_W-1:0]      in_col2_i,
    input  logic [IDX_W-1:0]         in_idx_col1,
    input  logic [IDX_W-1:0]         in_idx_col2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_r,
    output logic [DATA_W-1:0]        out_i,
    output logic [IDX_W+1:0]         out_addr,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    // Same layout as fft_pkg::beat_t but sized by this instance's parameters.
    typedef struct packed {
        logic [IDX_W-1:0]          idx_col2;
        logic [IDX_W-1:0]          idx_col1;
        logic [LANES*DATA_W-1:0]   col2_i;
        logic [LANES*DATA_W-1:0]   col2_r;
        logic [LANES*DATA_W-1:0]   col1_i;
        logic [LANES*DATA_W-1:0]   col1_r;
    } beat_local_t;

    beat_local_t        wr_beat;
    beat_local_t        head_beat;
    logic               fifo_full;
    logic               fifo_empty;
    logic               xfer;
    logic               last_xfer;
    logic               push_ok;
    logic               drop;
    logic [2:0]         sel_reg;
    logic [2:0]         sel_next;
    logic               overflow_reg;
    logic               overflow_next;
    logic [DATA_W-1:0]  lane_r [BEAT_SAMPLES];
    logic [DATA_W-1:0]  lane_i [BEAT_SAMPLES];

    always_comb begin
        wr_beat          = '0;
        wr_beat.col1_r   = in_col1_r;
        wr_beat.col1_i   = in_col1_i;
        wr_beat.col2_r   = in_col2_r;
        wr_beat.col2_i   = in_col2_i;
        wr_beat.idx_col1 = in_idx_col1;
        wr_beat.idx_col2 = in_idx_col2;
    end

    assign out_valid = !fifo_empty;
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (sel_reg == 3'd7);
    // Upstream cannot stall: a beat either fits (including the slot freed
    // by a head pop on this edge) or is lost.
    assign push_ok   = in_valid && (!fifo_full || last_xfer);
    assign drop      = in_valid && !push_ok;

    beat_fifo #(
        .T     (beat_local_t),
        .DEPTH (DEPTH)
    ) u_beat_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data (wr_beat),
        .pop       (last_xfer),
        .head      (head_beat),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Flatten the head beat into sample order: col1 lanes 0..3, col2 lanes 0..3.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_r[gi]         = head_beat.col1_r[gi*DATA_W +: DATA_W];
            assign lane_i[gi]         = head_beat.col1_i[gi*DATA_W +: DATA_W];
            assign lane_r[gi + LANES] = head_beat.col2_r[gi*DATA_W +: DATA_W];
            assign lane_i[gi + LANES] = head_beat.col2_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        sel_next      = sel_reg;
        overflow_next = overflow_reg | drop;
        if (xfer) begin
            sel_next = sel_reg + 3'd1;   // 7 wraps to 0 as the head pops
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            sel_reg      <= sel_next;
            overflow_reg <= overflow_next;
        end
    end

    assign out_r    = lane_r[sel_reg];
    assign out_i    = lane_i[sel_reg];
    assign out_addr = sel_reg[2] ? {head_beat.idx_col2, sel_reg[1:0]}
                                 : {head_beat.idx_col1, sel_reg[1:0]};
    assign out_last = (sel_reg == 3'd7);
    assign overflow = overflow_reg;

endmodule
